// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - RV32I instruction queue with head decode, operand merge and dispatch
//
// Purpose: buffers fetched instructions in a DEPTH-entry circular queue, decodes the
// head entry combinationally, merges register-file / ROB operand lookups, and
// dispatches one instruction per cycle into registered out_* fields when the ROB
// and the instruction's target (RS or LSB) can take it.
//
// Ports:
//   clk, rst (async active-low), rdy (global enable)
//   in_valid/in_instr/in_isjump/in_alt_pc, in_ready : fetch handshake
//   flush                                           : discard all queued work
//   rob_full, rs_full, lsb_full                     : back-pressure
//   rs1_idx, rs2_idx                                : head source indices (comb)
//   reg_rdy*/reg_val*, rob_rdy*/rob_val*            : operand lookups
//   out_*                                           : registered dispatch fields
//   count                                           : queue occupancy
//
// out_opcode ids: 0 none/illegal, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5-10 BEQ..BGEU,
// 11-15 LB,LH,LW,LBU,LHU, 16-18 SB,SH,SW, 19-27 ADDI,SLTI,SLTIU,XORI,ORI,ANDI,
// SLLI,SRLI,SRAI, 28-37 ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND.

module decode_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic             in_isjump,
  input  logic [31:0]      in_alt_pc,
  output logic             in_ready,
  input  logic             flush,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic [4:0]       rs1_idx,
  output logic [4:0]       rs2_idx,
  input  logic             reg_rdy1,
  input  logic             reg_rdy2,
  input  logic [31:0]      reg_val1,
  input  logic [31:0]      reg_val2,
  input  logic             rob_rdy1,
  input  logic             rob_rdy2,
  input  logic [31:0]      rob_val1,
  input  logic [31:0]      rob_val2,
  output logic             out_valid,
  output logic [4:0]       out_rd,
  output logic [5:0]       out_opcode,
  output logic [31:0]      out_imm,
  output logic             out_rdy1,
  output logic             out_rdy2,
  output logic [31:0]      out_val1,
  output logic [31:0]      out_val2,
  output logic             out_isjump,
  output logic [31:0]      out_alt_pc,
  output logic             out_to_rs,
  output logic             out_to_lsb,
  output logic             out_illegal,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [5:0] ID_NONE  = 6'd0;
  localparam logic [5:0] ID_LUI   = 6'd1;
  localparam logic [5:0] ID_AUIPC = 6'd2;
  localparam logic [5:0] ID_JAL   = 6'd3;
  localparam logic [5:0] ID_JALR  = 6'd4;
  localparam logic [5:0] ID_BEQ   = 6'd5;
  localparam logic [5:0] ID_BNE   = 6'd6;
  localparam logic [5:0] ID_BLT   = 6'd7;
  localparam logic [5:0] ID_BGE   = 6'd8;
  localparam logic [5:0] ID_BLTU  = 6'd9;
  localparam logic [5:0] ID_BGEU  = 6'd10;
  localparam logic [5:0] ID_LB    = 6'd11;
  localparam logic [5:0] ID_LH    = 6'd12;
  localparam logic [5:0] ID_LW    = 6'd13;
  localparam logic [5:0] ID_LBU   = 6'd14;
  localparam logic [5:0] ID_LHU   = 6'd15;
  localparam logic [5:0] ID_SB    = 6'd16;
  localparam logic [5:0] ID_SH    = 6'd17;
  localparam logic [5:0] ID_SW    = 6'd18;
  localparam logic [5:0] ID_ADDI  = 6'd19;
  localparam logic [5:0] ID_SLTI  = 6'd20;
  localparam logic [5:0] ID_SLTIU = 6'd21;
  localparam logic [5:0] ID_XORI  = 6'd22;
  localparam logic [5:0] ID_ORI   = 6'd23;
  localparam logic [5:0] ID_ANDI  = 6'd24;
  localparam logic [5:0] ID_SLLI  = 6'd25;
  localparam logic [5:0] ID_SRLI  = 6'd26;
  localparam logic [5:0] ID_SRAI  = 6'd27;
  localparam logic [5:0] ID_ADD   = 6'd28;
  localparam logic [5:0] ID_SUB   = 6'd29;
  localparam logic [5:0] ID_SLL   = 6'd30;
  localparam logic [5:0] ID_SLT   = 6'd31;
  localparam logic [5:0] ID_SLTU  = 6'd32;
  localparam logic [5:0] ID_XOR   = 6'd33;
  localparam logic [5:0] ID_SRL   = 6'd34;
  localparam logic [5:0] ID_SRA   = 6'd35;
  localparam logic [5:0] ID_OR    = 6'd36;
  localparam logic [5:0] ID_AND   = 6'd37;

  // Queue storage and pointers
  logic [31:0]      r_instr_mem  [DEPTH];
  logic             r_isjump_mem [DEPTH];
  logic [31:0]      r_alt_pc_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Registered dispatch fields
  logic        r_out_valid;
  logic [4:0]  r_out_rd;
  logic [5:0]  r_out_opcode;
  logic [31:0] r_out_imm;
  logic        r_out_rdy1;
  logic        r_out_rdy2;
  logic [31:0] r_out_val1;
  logic [31:0] r_out_val2;
  logic        r_out_isjump;
  logic [31:0] r_out_alt_pc;
  logic        r_out_to_rs;
  logic        r_out_to_lsb;
  logic        r_out_illegal;

  // Head decode
  logic [31:0] w_hi;
  logic        w_empty;
  logic [5:0]  w_op;
  logic [31:0] w_imm;
  logic        w_wr_rd;
  logic        w_use1;
  logic        w_use2;
  logic        w_to_rs;
  logic        w_to_lsb;
  logic        w_illegal;
  logic        w_target_free;
  logic        w_push;
  logic        w_pop;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_rdy1;
  logic        w_rdy2;
  logic [31:0] w_val1;
  logic [31:0] w_val2;

  assign w_hi     = r_instr_mem[r_head];
  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count != FULL_CNT);

  always_comb begin
    w_op     = ID_NONE;
    w_imm    = 32'd0;
    w_wr_rd  = 1'b0;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_to_rs  = 1'b0;
    w_to_lsb = 1'b0;
    case (w_hi[6:0])
      OPC_LUI: begin
        w_op = ID_LUI; w_imm = {w_hi[31:12], 12'd0}; w_wr_rd = 1'b1; w_to_rs = 1'b1;
      end
      OPC_AUIPC: begin
        w_op = ID_AUIPC; w_imm = {w_hi[31:12], 12'd0}; w_wr_rd = 1'b1; w_to_rs = 1'b1;
      end
      OPC_JAL: begin
        w_op = ID_JAL; w_wr_rd = 1'b1; w_to_rs = 1'b1;
        w_imm = {{11{w_hi[31]}}, w_hi[31], w_hi[19:12], w_hi[20], w_hi[30:21], 1'b0};
      end
      OPC_JALR: begin
        if (w_hi[14:12] == 3'b000) w_op = ID_JALR;
        w_imm = {{20{w_hi[31]}}, w_hi[31:20]};
        w_wr_rd = 1'b1; w_use1 = 1'b1; w_to_rs = 1'b1;
      end
      OPC_BRANCH: begin
        case (w_hi[14:12])
          3'b000:  w_op = ID_BEQ;
          3'b001:  w_op = ID_BNE;
          3'b100:  w_op = ID_BLT;
          3'b101:  w_op = ID_BGE;
          3'b110:  w_op = ID_BLTU;
          3'b111:  w_op = ID_BGEU;
          default: w_op = ID_NONE;
        endcase
        w_imm = {{19{w_hi[31]}}, w_hi[31], w_hi[7], w_hi[30:25], w_hi[11:8], 1'b0};
        w_use1 = 1'b1; w_use2 = 1'b1; w_to_rs = 1'b1;
      end
      OPC_LOAD: begin
        case (w_hi[14:12])
          3'b000:  w_op = ID_LB;
          3'b001:  w_op = ID_LH;
          3'b010:  w_op = ID_LW;
          3'b100:  w_op = ID_LBU;
          3'b101:  w_op = ID_LHU;
          default: w_op = ID_NONE;
        endcase
        w_imm = {{20{w_hi[31]}}, w_hi[31:20]};
        w_wr_rd = 1'b1; w_use1 = 1'b1; w_to_lsb = 1'b1;
      end
      OPC_STORE: begin
        case (w_hi[14:12])
          3'b000:  w_op = ID_SB;
          3'b001:  w_op = ID_SH;
          3'b010:  w_op = ID_SW;
          default: w_op = ID_NONE;
        endcase
        w_imm = {{20{w_hi[31]}}, w_hi[31:25], w_hi[11:7]};
        w_use1 = 1'b1; w_use2 = 1'b1; w_to_lsb = 1'b1;
      end
      OPC_OPIMM: begin
        case (w_hi[14:12])
          3'b000: w_op = ID_ADDI;
          3'b010: w_op = ID_SLTI;
          3'b011: w_op = ID_SLTIU;
          3'b100: w_op = ID_XORI;
          3'b110: w_op = ID_ORI;
          3'b111: w_op = ID_ANDI;
          3'b001: w_op = ID_SLLI;
          default: w_op = w_hi[30] ? ID_SRAI : ID_SRLI;
        endcase
        // Shifts carry an unsigned shamt in the immediate field
        if (w_hi[13:12] == 2'b01) w_imm = {27'd0, w_hi[24:20]};
        else                      w_imm = {{20{w_hi[31]}}, w_hi[31:20]};
        w_wr_rd = 1'b1; w_use1 = 1'b1; w_to_rs = 1'b1;
      end
      OPC_OP: begin
        case (w_hi[14:12])
          3'b000:  w_op = w_hi[30] ? ID_SUB : ID_ADD;
          3'b001:  w_op = ID_SLL;
          3'b010:  w_op = ID_SLT;
          3'b011:  w_op = ID_SLTU;
          3'b100:  w_op = ID_XOR;
          3'b101:  w_op = w_hi[30] ? ID_SRA : ID_SRL;
          3'b110:  w_op = ID_OR;
          default: w_op = ID_AND;
        endcase
        w_wr_rd = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; w_to_rs = 1'b1;
      end
      default: w_op = ID_NONE;
    endcase
    // Anything left unidentified becomes a bare ROB entry with no target or operands
    w_illegal = (w_op == ID_NONE);
    if (w_illegal) begin
      w_imm    = 32'd0;
      w_wr_rd  = 1'b0;
      w_use1   = 1'b0;
      w_use2   = 1'b0;
      w_to_rs  = 1'b0;
      w_to_lsb = 1'b0;
    end
  end

  // Unused or x0 sources collapse to index 0, which the merge treats as ready/zero
  assign w_rs1   = (!w_empty && w_use1) ? w_hi[19:15] : 5'd0;
  assign w_rs2   = (!w_empty && w_use2) ? w_hi[24:20] : 5'd0;
  assign rs1_idx = w_rs1;
  assign rs2_idx = w_rs2;

  assign w_rdy1 = (w_rs1 == 5'd0) | reg_rdy1 | rob_rdy1;
  assign w_rdy2 = (w_rs2 == 5'd0) | reg_rdy2 | rob_rdy2;
  assign w_val1 = (w_rs1 == 5'd0) ? 32'd0 : (reg_rdy1 ? reg_val1 : rob_val1);
  assign w_val2 = (w_rs2 == 5'd0) ? 32'd0 : (reg_rdy2 ? reg_val2 : rob_val2);

  assign w_target_free = w_to_lsb ? !lsb_full : (w_to_rs ? !rs_full : 1'b1);
  assign w_push = rdy && in_valid && in_ready && !flush;
  assign w_pop  = rdy && !flush && !w_empty && !rob_full && w_target_free;

  // Payload storage needs no reset: occupancy is tracked solely by the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_tail]  <= in_instr;
      r_isjump_mem[r_tail] <= in_isjump;
      r_alt_pc_mem[r_tail] <= in_alt_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_out_valid   <= 1'b0;
      r_out_rd      <= 5'd0;
      r_out_opcode  <= 6'd0;
      r_out_imm     <= 32'd0;
      r_out_rdy1    <= 1'b0;
      r_out_rdy2    <= 1'b0;
      r_out_val1    <= 32'd0;
      r_out_val2    <= 32'd0;
      r_out_isjump  <= 1'b0;
      r_out_alt_pc  <= 32'd0;
      r_out_to_rs   <= 1'b0;
      r_out_to_lsb  <= 1'b0;
      r_out_illegal <= 1'b0;
    end else begin
      r_out_valid <= w_pop;
      if (rdy && flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PTR_W'(1);
        if (w_pop)  r_head <= r_head + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
      if (w_pop) begin
        r_out_rd      <= w_wr_rd ? w_hi[11:7] : 5'd0;
        r_out_opcode  <= w_op;
        r_out_imm     <= w_imm;
        r_out_rdy1    <= w_rdy1;
        r_out_rdy2    <= w_rdy2;
        r_out_val1    <= w_val1;
        r_out_val2    <= w_val2;
        r_out_isjump  <= r_isjump_mem[r_head];
        r_out_alt_pc  <= r_alt_pc_mem[r_head];
        r_out_to_rs   <= w_to_rs;
        r_out_to_lsb  <= w_to_lsb;
        r_out_illegal <= w_illegal;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_rd      = r_out_rd;
  assign out_opcode  = r_out_opcode;
  assign out_imm     = r_out_imm;
  assign out_rdy1    = r_out_rdy1;
  assign out_rdy2    = r_out_rdy2;
  assign out_val1    = r_out_val1;
  assign out_val2    = r_out_val2;
  assign out_isjump  = r_out_isjump;
  assign out_alt_pc  = r_out_alt_pc;
  assign out_to_rs   = r_out_to_rs;
  assign out_to_lsb  = r_out_to_lsb;
  assign out_illegal = r_out_illegal;
  assign count       = r_count;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - scoreboard bench for decode_queue

module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, in_valid, in_isjump, flush;
  logic [31:0] in_instr, in_alt_pc;
  logic        in_ready;
  logic        rob_full, rs_full, lsb_full;
  logic [4:0]  rs1_idx, rs2_idx;
  logic        reg_rdy1, reg_rdy2, rob_rdy1, rob_rdy2;
  logic [31:0] reg_val1, reg_val2, rob_val1, rob_val2;
  logic        out_valid, out_rdy1, out_rdy2, out_isjump, out_to_rs, out_to_lsb, out_illegal;
  logic [4:0]  out_rd;
  logic [5:0]  out_opcode;
  logic [31:0] out_imm, out_val1, out_val2, out_alt_pc;
  logic [2:0]  count;

  decode_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_valid(in_valid), .in_instr(in_instr), .in_isjump(in_isjump), .in_alt_pc(in_alt_pc),
    .in_ready(in_ready), .flush(flush),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .reg_rdy1(reg_rdy1), .reg_rdy2(reg_rdy2), .reg_val1(reg_val1), .reg_val2(reg_val2),
    .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2), .rob_val1(rob_val1), .rob_val2(rob_val2),
    .out_valid(out_valid), .out_rd(out_rd), .out_opcode(out_opcode), .out_imm(out_imm),
    .out_rdy1(out_rdy1), .out_rdy2(out_rdy2), .out_val1(out_val1), .out_val2(out_val2),
    .out_isjump(out_isjump), .out_alt_pc(out_alt_pc), .out_to_rs(out_to_rs),
    .out_to_lsb(out_to_lsb), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        to_rs;
    logic        to_lsb;
    logic        ill;
    logic        rdy1;
    logic [31:0] val1;
    logic        rdy2;
    logic [31:0] val2;
    logic        isjump;
    logic [31:0] alt_pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [31:0] RV1 = 32'hAAAA0001;
  localparam logic [31:0] RV2 = 32'hBBBB0002;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] imm,
                              input logic to_rs, input logic to_lsb, input logic ill,
                              input logic rdy1, input logic [31:0] val1,
                              input logic rdy2, input logic [31:0] val2);
    exp_t e;
    e.op = op; e.rd = rd; e.imm = imm; e.to_rs = to_rs; e.to_lsb = to_lsb; e.ill = ill;
    e.rdy1 = rdy1; e.val1 = val1; e.rdy2 = rdy2; e.val2 = val2;
    e.isjump = 1'b0; e.alt_pc = 32'd0;
    return e;
  endfunction

  // Scoreboard: every dispatch pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_dispatch", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("opcode",  32'(out_opcode),  32'(e.op));
        check("rd",      32'(out_rd),      32'(e.rd));
        check("imm",     out_imm,          e.imm);
        check("to_rs",   32'(out_to_rs),   32'(e.to_rs));
        check("to_lsb",  32'(out_to_lsb),  32'(e.to_lsb));
        check("illegal", 32'(out_illegal), 32'(e.ill));
        check("rdy1",    32'(out_rdy1),    32'(e.rdy1));
        check("val1",    out_val1,         e.val1);
        check("rdy2",    32'(out_rdy2),    32'(e.rdy2));
        check("val2",    out_val2,         e.val2);
        check("isjump",  32'(out_isjump),  32'(e.isjump));
        check("alt_pc",  out_alt_pc,       e.alt_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic isj, input logic [31:0] apc,
                      input logic sb, input exp_t e_in);
    exp_t e;
    e = e_in;
    e.isjump = isj;
    e.alt_pc = apc;
    in_instr = ins; in_isjump = isj; in_alt_pc = apc; in_valid = 1'b1;
    if (sb) exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  exp_t nul;

  initial begin
    nul = mk(6'd0, 5'd0, 32'd0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
    rst = 1'b0; rdy = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_isjump = 1'b0;
    in_alt_pc = 32'd0; flush = 1'b0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    reg_rdy1 = 1'b1; reg_rdy2 = 1'b1; reg_val1 = RV1; reg_val2 = RV2;
    rob_rdy1 = 1'b0; rob_rdy2 = 1'b0; rob_val1 = 32'hDEAD0001; rob_val2 = 32'hDEAD0002;
    repeat (3) tick();
    check("rst_count",    32'(count),      32'd0);
    check("rst_in_ready", 32'(in_ready),   32'd1);
    check("rst_valid",    32'(out_valid),  32'd0);
    check("rst_rs1_idx",  32'(rs1_idx),    32'd0);
    rst = 1'b1;

    // ADDI x5,x0,-1: dispatch one edge after the push, never the same edge
    push(32'hFFF00293, 1'b0, 32'h1000, 1'b1,
         mk(6'd19, 5'd5, 32'hFFFFFFFF, 1, 0, 0, 1, 32'd0, 1, 32'd0));
    check("addi_no_bypass", 32'(out_valid), 32'd0);
    check("addi_count1",    32'(count),     32'd1);
    tick();
    check("addi_count0",    32'(count),     32'd0);

    // Fill to full under ROB back-pressure, then drain in FIFO order
    rob_full = 1'b1;
    push(32'h003100B3, 1'b0, 32'h2000, 1'b1, mk(6'd28, 5'd1, 32'd0, 1, 0, 0, 1, RV1, 1, RV2));
    push(32'h40628233, 1'b1, 32'h2004, 1'b1, mk(6'd29, 5'd4, 32'd0, 1, 0, 0, 1, RV1, 1, RV2));
    push(32'h00712423, 1'b0, 32'h2008, 1'b1, mk(6'd18, 5'd0, 32'd8, 0, 1, 0, 1, RV1, 1, RV2));
    push(32'h4054D413, 1'b0, 32'h200C, 1'b1, mk(6'd27, 5'd8, 32'd5, 1, 0, 0, 1, RV1, 1, 32'd0));
    check("full_count",    32'(count),    32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    push(32'hFF9FF0EF, 1'b1, 32'h9999, 1'b0, nul);
    check("full_reject", 32'(count), 32'd4);
    rob_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_count", 32'(count), 32'(3 - i));
    end
    push(32'h12345537, 1'b0, 32'h3000, 1'b1, mk(6'd1, 5'd10, 32'h12345000, 1, 0, 0, 1, 32'd0, 1, 32'd0));
    push(32'hFF9FF0EF, 1'b1, 32'h3004, 1'b1, mk(6'd3, 5'd1, 32'hFFFFFFF8, 1, 0, 0, 1, 32'd0, 1, 32'd0));
    tick();
    check("wrap_count", 32'(count), 32'd0);

    // LW x5,4(x3) stalled by the LSB, source forwarded from the ROB
    reg_rdy1 = 1'b0; rob_rdy1 = 1'b1; rob_val1 = 32'h100; lsb_full = 1'b1;
    push(32'h0041A283, 1'b0, 32'h4000, 1'b1, mk(6'd13, 5'd5, 32'd4, 0, 1, 0, 1, 32'h100, 1, 32'd0));
    check("lw_rs1_idx", 32'(rs1_idx), 32'd3);
    check("lw_rs2_idx", 32'(rs2_idx), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("lw_stall_valid", 32'(out_valid), 32'd0);
      check("lw_stall_count", 32'(count),     32'd1);
      tick();
    end
    lsb_full = 1'b0;
    tick();
    reg_rdy1 = 1'b1; rob_rdy1 = 1'b0; rob_val1 = 32'hDEAD0001;

    // Illegal word needs only a ROB slot; rdy low freezes everything
    rob_full = 1'b1; rs_full = 1'b1; lsb_full = 1'b1;
    push(32'hFFFFFFFF, 1'b0, 32'h5000, 1'b1, mk(6'd0, 5'd0, 32'd0, 0, 0, 1, 1, 32'd0, 1, 32'd0));
    rdy = 1'b0; rob_full = 1'b0; in_valid = 1'b1; in_instr = 32'h003100B3;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rdy_low_count", 32'(count),     32'd1);
      check("rdy_low_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0; rdy = 1'b1;
    tick();
    rs_full = 1'b0; lsb_full = 1'b0;

    // BEQ x1,x2,-4 and a load with an undefined funct3
    push(32'hFE208EE3, 1'b0, 32'h6000, 1'b1, mk(6'd5, 5'd0, 32'hFFFFFFFC, 1, 0, 0, 1, RV1, 1, RV2));
    push(32'h0041B283, 1'b0, 32'h6004, 1'b1, mk(6'd0, 5'd0, 32'd0, 0, 0, 1, 1, 32'd0, 1, 32'd0));
    tick();

    // Flush with three queued and a simultaneous push
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h003100B3, 1'b0, 32'h7000, 1'b0, nul);
    check("pre_flush_count", 32'(count), 32'd3);
    rob_full = 1'b0; flush = 1'b1; in_valid = 1'b1; in_instr = 32'h12345537;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count",    32'(count),     32'd0);
    check("flush_valid",    32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready),  32'd1);
    repeat (2) tick();
    check("post_flush_count", 32'(count), 32'd0);

    // Asynchronous reset mid-burst
    rob_full = 1'b1;
    push(32'h003100B3, 1'b0, 32'h8000, 1'b1, mk(6'd28, 5'd1, 32'd0, 1, 0, 0, 1, RV1, 1, RV2));
    push(32'h40628233, 1'b0, 32'h8004, 1'b0, nul);
    push(32'h00712423, 1'b0, 32'h8008, 1'b0, nul);
    rob_full = 1'b0;
    tick();
    check("pre_rst_count", 32'(count), 32'd2);
    rob_full = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_valid",    32'(out_valid),  32'd0);
    check("arst_count",    32'(count),      32'd0);
    check("arst_rd",       32'(out_rd),     32'd0);
    check("arst_opcode",   32'(out_opcode), 32'd0);
    check("arst_val1",     out_val1,        32'd0);
    check("arst_alt_pc",   out_alt_pc,      32'd0);
    check("arst_in_ready", 32'(in_ready),   32'd1);
    rob_full = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    push(32'h12345537, 1'b0, 32'h9000, 1'b1, mk(6'd1, 5'd10, 32'h12345000, 1, 0, 0, 1, 32'd0, 1, 32'd0));
    check("first_push_count", 32'(count), 32'd1);
    repeat (4) tick();
    check("final_count", 32'(count), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction queue entries; power of two, at least 2.
REQ-002 Parameter CNT_W, default 3, count width, equal to log2(DEPTH)+1.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 rdy  in  1  global enable; when low, no state change except the out_valid clear (REQ-017).
REQ-006 in_valid  in  1  fetch offers an instruction.
REQ-007 in_instr  in  32  RV32I instruction.
REQ-008 in_isjump  in  1  predicted-taken flag.
REQ-009 in_alt_pc  in  32  recovery PC on mispredict.
REQ-010 in_ready  out  1  queue can accept; equals (count != DEPTH).
REQ-011 flush  in  1  mispredict recovery; discards all queued work.
REQ-012 rob_full, rs_full, lsb_full  in  1 each  back-pressure from ROB, reservation station and load/store buffer.
REQ-013 rs1_idx, rs2_idx  out  5 each  head-entry source indices, combinational; 0 when the queue is empty.
REQ-014 reg_rdy1, reg_rdy2  in  1 each; reg_val1, reg_val2  in  32 each  register file lookups.
REQ-015 rob_rdy1, rob_rdy2  in  1 each; rob_val1, rob_val2  in  32 each  ROB forwarding lookups.
REQ-016 Registered outputs: out_valid (1), out_rd (5), out_opcode (6, op_map ids), out_imm (32), out_rdy1, out_rdy2 (1 each), out_val1, out_val2 (32 each), out_isjump (1), out_alt_pc (32), out_to_rs (1), out_to_lsb (1), out_illegal (1), count (CNT_W).

Function
REQ-017 out_valid is a one-cycle pulse per dispatched instruction; it clears on every edge without a pop, including edges with rdy low.
REQ-018 Push on an edge with rdy && in_valid && in_ready && !flush: write instr, isjump and alt_pc at the tail; the tail advances modulo DEPTH.
REQ-019 Pop on an edge with rdy && !flush && count>0 && !rob_full && target free.
- Target is the RS for ALU, branch, JAL, JALR, LUI and AUIPC; it is free when !rs_full.
- Target is the LSB for loads and stores; it is free when !lsb_full.
- Illegal instructions have no target beyond the ROB.
REQ-020 A pop registers the decoded head into all out_* fields and advances the head modulo DEPTH.
REQ-021 Minimum latency: an instruction pushed at edge E pops no earlier than edge E+1; no bypass from the empty queue.
REQ-022 Push and pop on the same edge leave count unchanged; push alone adds 1; pop alone subtracts 1.
REQ-023 Full queue: in_ready=0, so no push that cycle even if a pop occurs.
REQ-024 Decode covers all 37 RV32I ops, BEQ included.
- Immediates are sign-extended per type (I, S, B, U, J).
- B and J immediates have bit 0 = 0.
- SLLI, SRLI and SRAI use a zero-extended shamt.
- funct7[5] selects SUB/SRA/SRAI.
REQ-025 Unknown opcode or funct3: out_illegal=1, out_to_rs=0, out_to_lsb=0, out_opcode=0; the instruction still takes a ROB slot.
REQ-026 Operand merge, per source: ready = reg_rdy | rob_rdy; val = reg_val if reg_rdy, else rob_val.
REQ-027 An index of x0, or a source the format does not use, gives ready=1, val=0.
- rs1 is unused by LUI, AUIPC and JAL.
- rs2 is unused by I, U and J formats and by loads.
REQ-028 out_rd is instr[11:7] for formats that write rd, else 0 (stores, branches).
REQ-029 Flush empties the queue in one edge: head=tail=count=0 and out_valid=0.
- Flush overrides a simultaneous push and pop.
- in_ready=1 in the next cycle.
REQ-030 rdy low: queue contents, pointers and count hold.

Reset
REQ-031 rst low forces count=0, head=tail=0, in_ready=1 and every out_* register to 0, immediately and independent of clk.
REQ-032 Release is synchronized by design; the first push is accepted on the first edge with rst high.
REQ-033 Reset mid-operation discards queued instructions with no dispatch.

Verification
REQ-034 Push ADDI x5,x0,-1 (0xFFF00293) into an empty queue -> one edge later out_valid=1, out_opcode=ADDI, out_rd=5, out_imm=0xFFFFFFFF, out_rdy1=1, out_val1=0, out_to_rs=1.
REQ-035 Fill 4 entries with rob_full=1 -> in_ready=0, count=4; release rob_full -> 4 consecutive out_valid pulses in FIFO order, with pointer wrap on a fifth push.
REQ-036 LW with rs1=x3, reg_rdy1=0, rob_rdy1=1, rob_val1=0x100, lsb_full=1 for 3 cycles -> no dispatch; then out_to_lsb=1, out_rdy1=1, out_val1=0x100.
REQ-037 Flush asserted with count=3 plus a simultaneous push -> next cycle count=0, out_valid=0, in_ready=1.
REQ-038 Instruction 0xFFFFFFFF -> out_illegal=1, out_to_rs=0, out_to_lsb=0; BEQ x1,x2,-4 -> out_imm=0xFFFFFFFC.
REQ-039 Assert rst low mid-burst with count=2 -> all outputs 0 asynchronously, and no out_valid after release.
